// File: rtl/control_unit_if.sv
// Control bundle between the LC-3 control unit and the datapath/memory.
// Handshake: in a memory state the control unit holds mem_en (and mem_we for
// stores) high. The access completes on the first rising clk edge at which
// mem_ready is sampled high. mem_ready is ignored in every other state.
interface control_unit_if;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        mem_ready;
    logic        ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc;
    logic        gate_alu, gate_pc, gate_marmux, gate_mdr;
    logic [2:0]  dr, sr1, sr2;
    logic [1:0]  aluk;
    logic        a1m_sel;
    logic [1:0]  a2m_sel;
    logic [1:0]  pcmux_sel;
    logic        marmux_sel;
    logic        mio_en;
    logic        mem_en, mem_we;
    logic        halted;
    logic        mem_fault;
    logic [3:0]  state;

    // Control unit side
    modport master (
        input  ir, nzp, mem_ready,
        output ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc,
        output gate_alu, gate_pc, gate_marmux, gate_mdr,
        output dr, sr1, sr2, aluk, a1m_sel, a2m_sel, pcmux_sel, marmux_sel,
        output mio_en, mem_en, mem_we, halted, mem_fault, state
    );

    // Datapath / memory side
    modport slave (
        output ir, nzp, mem_ready,
        input  ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc,
        input  gate_alu, gate_pc, gate_marmux, gate_mdr,
        input  dr, sr1, sr2, aluk, a1m_sel, a2m_sel, pcmux_sel, marmux_sel,
        input  mio_en, mem_en, mem_we, halted, mem_fault, state
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle LC-3 control FSM: fetch, decode and execute for
// ADD/AND/NOT/BR/JMP/LD/ST/LEA/TRAP(halt), with a memory wait timeout.
module control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_F1   = 4'd0,
        S_F2   = 4'd1,
        S_F3   = 4'd2,
        S_DEC  = 4'd3,
        S_ALU  = 4'd4,
        S_BR   = 4'd5,
        S_JMP  = 4'd6,
        S_LEA  = 4'd7,
        S_LD1  = 4'd8,
        S_LD2  = 4'd9,
        S_LD3  = 4'd10,
        S_ST1  = 4'd11,
        S_ST2  = 4'd12,
        S_ST3  = 4'd13,
        S_ILL  = 4'd14,
        S_HALT = 4'd15
    } state_t;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // Counter value during the last low-ready cycle that is still tolerated
    localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    state_t        state_q;
    logic [CW-1:0] wait_q;
    logic          fault_q;
    logic          timeout_hit;
    logic          br_taken;

    // The wait that would bring the counter to MEM_TIMEOUT with ready still low gives up
    assign timeout_hit = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_q == WAIT_LAST);
    assign br_taken    = (bus.ir[11:9] & bus.nzp) != 3'b000;

    // State sequencing, memory wait counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_F1;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_F1: begin
                    state_q <= S_F2;
                    wait_q  <= '0;
                end
                S_F2, S_LD2, S_ST3: begin
                    if (bus.mem_ready) begin
                        if (state_q == S_F2)       state_q <= S_F3;
                        else if (state_q == S_LD2) state_q <= S_LD3;
                        else                       state_q <= S_F1;
                    end else if (timeout_hit) begin
                        state_q <= S_HALT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                S_F3: state_q <= S_DEC;
                S_DEC: begin
                    case (bus.ir[15:12])
                        4'b0001, 4'b0101, 4'b1001: state_q <= S_ALU;
                        4'b0000: state_q <= S_BR;
                        4'b1100: state_q <= S_JMP;
                        4'b1110: state_q <= S_LEA;
                        4'b0010: state_q <= S_LD1;
                        4'b0011: state_q <= S_ST1;
                        4'b1111: state_q <= S_HALT;
                        default: state_q <= S_ILL;
                    endcase
                end
                S_LD1: begin
                    state_q <= S_LD2;
                    wait_q  <= '0;
                end
                S_ST1: state_q <= S_ST2;
                S_ST2: begin
                    state_q <= S_ST3;
                    wait_q  <= '0;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_F1;
            endcase
        end
    end

    // Moore control decode; BR target load follows nzp, read-state ld_mdr follows mem_ready
    always_comb begin
        bus.ld_ir       = 1'b0;
        bus.ld_reg      = 1'b0;
        bus.ld_pc       = 1'b0;
        bus.ld_mar      = 1'b0;
        bus.ld_mdr      = 1'b0;
        bus.ld_cc       = 1'b0;
        bus.gate_alu    = 1'b0;
        bus.gate_pc     = 1'b0;
        bus.gate_marmux = 1'b0;
        bus.gate_mdr    = 1'b0;
        bus.dr          = bus.ir[11:9];
        bus.sr1         = bus.ir[8:6];
        bus.sr2         = bus.ir[2:0];
        bus.aluk        = 2'b00;
        bus.a1m_sel     = 1'b0;
        bus.a2m_sel     = 2'b00;
        bus.pcmux_sel   = 2'b00;
        bus.marmux_sel  = 1'b0;
        bus.mio_en      = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.halted      = 1'b0;
        bus.mem_fault   = fault_q;
        bus.state       = state_q;
        case (state_q)
            S_F1: begin
                bus.gate_pc   = 1'b1;
                bus.ld_mar    = 1'b1;
                bus.ld_pc     = 1'b1;
                bus.pcmux_sel = 2'b10;
            end
            S_F2, S_LD2: begin
                bus.mem_en = 1'b1;
                bus.mio_en = 1'b1;
                bus.ld_mdr = bus.mem_ready;
            end
            S_F3: begin
                bus.gate_mdr = 1'b1;
                bus.ld_ir    = 1'b1;
            end
            S_ALU: begin
                bus.gate_alu = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
                case (bus.ir[15:12])
                    4'b0001: bus.aluk = 2'b10;
                    4'b0101: bus.aluk = 2'b01;
                    default: bus.aluk = 2'b00;
                endcase
            end
            S_BR: begin
                if (br_taken) begin
                    bus.a2m_sel   = 2'b10;
                    bus.pcmux_sel = 2'b01;
                    bus.ld_pc     = 1'b1;
                end
            end
            S_JMP: begin
                bus.a1m_sel   = 1'b1;
                bus.pcmux_sel = 2'b01;
                bus.ld_pc     = 1'b1;
            end
            S_LEA: begin
                bus.a2m_sel     = 2'b10;
                bus.marmux_sel  = 1'b1;
                bus.gate_marmux = 1'b1;
                bus.ld_reg      = 1'b1;
            end
            S_LD1, S_ST1: begin
                bus.a2m_sel     = 2'b10;
                bus.marmux_sel  = 1'b1;
                bus.gate_marmux = 1'b1;
                bus.ld_mar      = 1'b1;
            end
            S_LD3: begin
                bus.gate_mdr = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
            end
            S_ST2: begin
                bus.sr1      = bus.ir[11:9];
                bus.aluk     = 2'b11;
                bus.gate_alu = 1'b1;
                bus.ld_mdr   = 1'b1;
            end
            S_ST3: begin
                bus.mem_en = 1'b1;
                bus.mem_we = 1'b1;
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
        // Reset silences every output, including the abandoned memory request
        if (rst) begin
            bus.ld_ir       = 1'b0;
            bus.ld_reg      = 1'b0;
            bus.ld_pc       = 1'b0;
            bus.ld_mar      = 1'b0;
            bus.ld_mdr      = 1'b0;
            bus.ld_cc       = 1'b0;
            bus.gate_alu    = 1'b0;
            bus.gate_pc     = 1'b0;
            bus.gate_marmux = 1'b0;
            bus.gate_mdr    = 1'b0;
            bus.dr          = 3'b000;
            bus.sr1         = 3'b000;
            bus.sr2         = 3'b000;
            bus.aluk        = 2'b00;
            bus.a1m_sel     = 1'b0;
            bus.a2m_sel     = 2'b00;
            bus.pcmux_sel   = 2'b00;
            bus.marmux_sel  = 1'b0;
            bus.mio_en      = 1'b0;
            bus.mem_en      = 1'b0;
            bus.mem_we      = 1'b0;
            bus.halted      = 1'b0;
            bus.mem_fault   = 1'b0;
            bus.state       = 4'd0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ADD, BR taken/not taken, LD with wait
// states, ST, illegal opcode, memory timeout, reset and HALT.
module tb_control_unit;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    control_unit_if cu ();

    control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cu)
    );

    wire [35:0] all_outs = {cu.ld_ir, cu.ld_reg, cu.ld_pc, cu.ld_mar, cu.ld_mdr, cu.ld_cc,
                            cu.gate_alu, cu.gate_pc, cu.gate_marmux, cu.gate_mdr,
                            cu.dr, cu.sr1, cu.sr2, cu.aluk, cu.a1m_sel, cu.a2m_sel,
                            cu.pcmux_sel, cu.marmux_sel, cu.mio_en, cu.mem_en, cu.mem_we,
                            cu.halted, cu.mem_fault, cu.state};
    wire [3:0] gates = {cu.gate_alu, cu.gate_pc, cu.gate_marmux, cu.gate_mdr};

    // clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle away from the edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // at most one bus driver in any cycle
    always @(negedge clk) begin
        checks++;
        assert ($countones(gates) <= 1) else begin
            errors++;
            $error("FAIL gate_onehot observed=%b expected=at most one set", gates);
        end
    end

    initial begin
        rst          = 1'b1;
        cu.ir        = 16'hFFFF;
        cu.nzp       = 3'b111;
        cu.mem_ready = 1'b1;
        cyc();
        cyc();
        chk("reset_all_zero", all_outs, 36'd0);

        // ADD R0,R1,R2
        cu.ir = 16'h1042;
        cu.nzp = 3'b000;
        rst = 1'b0;
        #1;
        chk("add_f1_state", cu.state, 4'd0);
        chk("add_f1_ctl", {cu.gate_pc, cu.ld_mar, cu.ld_pc, cu.pcmux_sel}, {3'b111, 2'b10});
        cyc();
        chk("add_f2_state", cu.state, 4'd1);
        chk("add_f2_ctl", {cu.mem_en, cu.mio_en, cu.ld_mdr, cu.mem_we}, 4'b1110);
        cyc();
        chk("add_f3_state", cu.state, 4'd2);
        chk("add_f3_ctl", {cu.gate_mdr, cu.ld_ir}, 2'b11);
        cyc();
        chk("add_dec_state", cu.state, 4'd3);
        chk("add_dec_loads", {cu.ld_ir, cu.ld_reg, cu.ld_pc, cu.ld_mar, cu.ld_mdr, cu.ld_cc, gates}, 10'd0);
        cyc();
        chk("add_alu_state", cu.state, 4'd4);
        chk("add_alu_regs", {cu.dr, cu.sr1, cu.sr2}, {3'd0, 3'd1, 3'd2});
        chk("add_alu_ctl", {cu.aluk, cu.gate_alu, cu.ld_reg, cu.ld_cc}, {2'b10, 3'b111});
        cyc();
        chk("add_back_f1", cu.state, 4'd0);

        // BR z, taken
        cu.ir = 16'h0405;
        cu.nzp = 3'b010;
        cyc(); cyc(); cyc();
        chk("br_dec_state", cu.state, 4'd3);
        cyc();
        chk("br_t_state", cu.state, 4'd5);
        chk("br_t_ctl", {cu.ld_pc, cu.pcmux_sel, cu.a2m_sel, cu.a1m_sel}, {1'b1, 2'b01, 2'b10, 1'b0});
        cyc();
        chk("br_t_back_f1", cu.state, 4'd0);

        // BR z, not taken with N set
        cu.nzp = 3'b100;
        cyc(); cyc(); cyc(); cyc();
        chk("br_nt_state", cu.state, 4'd5);
        chk("br_nt_ldpc", cu.ld_pc, 1'b0);
        cyc();
        chk("br_nt_back_f1", cu.state, 4'd0);

        // LD R1, with three wait cycles in LD2
        cu.ir = 16'h2203;
        cyc(); cyc(); cyc(); cyc();
        chk("ld1_state", cu.state, 4'd8);
        chk("ld1_ctl", {cu.gate_marmux, cu.ld_mar, cu.marmux_sel, cu.a2m_sel, cu.ld_reg},
            {3'b111, 2'b10, 1'b0});
        cu.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ld2_wait_state", cu.state, 4'd9);
            chk("ld2_wait_ctl", {cu.mem_en, cu.ld_mdr}, 2'b10);
        end
        cyc();
        cu.mem_ready = 1'b1;
        #1;
        chk("ld2_ready_state", cu.state, 4'd9);
        chk("ld2_ready_ctl", {cu.mem_en, cu.ld_mdr}, 2'b11);
        cyc();
        chk("ld3_state", cu.state, 4'd10);
        chk("ld3_ctl", {cu.gate_mdr, cu.ld_reg, cu.ld_cc, cu.mem_en, cu.ld_mdr}, 5'b11100);
        chk("ld3_no_fault", cu.mem_fault, 1'b0);
        cyc();
        chk("ld_back_f1", cu.state, 4'd0);

        // ST R3
        cu.ir = 16'h3604;
        cyc(); cyc(); cyc(); cyc();
        chk("st1_state", cu.state, 4'd11);
        chk("st1_ctl", {cu.gate_marmux, cu.ld_mar, cu.marmux_sel}, 3'b111);
        cyc();
        chk("st2_state", cu.state, 4'd12);
        chk("st2_ctl", {cu.sr1, cu.aluk, cu.gate_alu, cu.ld_mdr, cu.mio_en, cu.mem_en},
            {3'd3, 2'b11, 4'b1100});
        cu.mem_ready = 1'b0;
        cyc();
        chk("st3_wait", {cu.state, cu.mem_en, cu.mem_we}, {4'd13, 2'b11});
        cyc();
        chk("st3_wait2", {cu.state, cu.mem_en, cu.mem_we}, {4'd13, 2'b11});
        cu.mem_ready = 1'b1;
        cyc();
        chk("st_back_f1", {cu.state, cu.mem_en, cu.mem_we}, {4'd0, 2'b00});

        // illegal opcode 1101
        cu.ir = 16'hD000;
        cyc(); cyc(); cyc();
        chk("ill_dec", cu.state, 4'd3);
        cyc();
        chk("ill_state", cu.state, 4'd14);
        chk("ill_ctl", {cu.ld_ir, cu.ld_reg, cu.ld_pc, cu.ld_mar, cu.ld_mdr, cu.ld_cc, gates,
                        cu.mem_en, cu.halted}, 12'd0);
        cyc();
        chk("ill_back_f1", cu.state, 4'd0);

        // memory timeout in F2
        cu.ir = 16'h1042;
        cu.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("to_f2_wait", {cu.state, cu.mem_en, cu.mem_fault}, {4'd1, 2'b10});
        end
        cyc();
        chk("to_halt", {cu.state, cu.halted, cu.mem_fault, cu.mem_en}, {4'd15, 3'b110});
        cyc();
        chk("to_halt_hold", {cu.state, cu.halted, cu.mem_fault}, {4'd15, 2'b11});
        rst = 1'b1;
        #1;
        chk("to_rst_outs", all_outs, 36'd0);
        cyc();
        chk("to_rst_outs2", all_outs, 36'd0);
        rst = 1'b0;
        #1;
        chk("to_rst_release", {cu.state, cu.mem_fault, cu.halted, cu.gate_pc}, {4'd0, 3'b001});

        // TRAP halts and holds
        cu.ir = 16'hF025;
        cu.mem_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("halt_entry", {cu.state, cu.halted, cu.mem_fault}, {4'd15, 2'b10});
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halt_hold", {cu.state, cu.halted, cu.mem_en, cu.ld_pc}, {4'd15, 3'b100});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
